material_table_db: RTL and testbench
====================================

# material_table_db

Parametrised, double-buffered material table for the ray tracer's shading stage. Host-side writes land in a shadow bank. A commit request copies only the entries written since the last commit into the active bank, one entry per cycle, while the active bank keeps serving reads. `NUM_RD` independent registered read ports return ambient, diffuse and reflection colours plus the `is_diffuse` flag for a material id.

## Interface
Parameters:
- `NUM_MATS`, 8: number of material entries; range 2..64, need not be a power of 2.
- `COLOR_W`, 32: width of one colour channel, fixed point with 24 fractional bits (1.0 = 0x0100_0000).
- `NUM_RD`, 2: number of independent read ports.
- Derived values:
  - `ID_W` = clog2(`NUM_MATS`).
  - `ENTRY_W` = 9·`COLOR_W`+1.
  - Entry layout, LSB first: ambient RGB, diffuse RGB, reflection RGB, then `is_diffuse`.

Ports:
- `clk`, in, 1: the single clock. Reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: write the shadow entry selected by `wr_id`.
- `wr_id`, in, `ID_W`: shadow entry index.
- `wr_data`, in, `ENTRY_W`: material record to write.
- `commit_req`, in, 1: single-cycle pulse requesting a shadow-to-active commit.
- `busy`, out, 1: a commit is in progress.
- `commit_done`, out, 1: one-cycle pulse when a commit finishes.
- `rd_id`, in, `NUM_RD`·`ID_W`: packed read ids, one per port.
- `rd_ambient`, out, `NUM_RD`·3·`COLOR_W`: ambient colour per port.
- `rd_diffuse`, out, `NUM_RD`·3·`COLOR_W`: diffuse colour per port.
- `rd_reflection`, out, `NUM_RD`·3·`COLOR_W`: reflection colour per port.
- `rd_is_diffuse`, out, `NUM_RD`: diffuse flag per port.

## Operation
- Power-up contents:
  - Active entries 0, 1, 2: ambient (1.0, 1.0, 1.0), diffuse pure red, pure green and pure blue (1.0 in one channel), reflection 0, `is_diffuse`=1.
  - All other active entries and all shadow entries are 0.
- `rst` clears control state only; table contents are never reset.
- Dirty mask, `NUM_MATS` bits: `wr_en` sets bit `wr_id`. A `wr_id` ≥ `NUM_MATS` is ignored.
- FSM states and transitions:
  - IDLE: a `commit_req` (or a pending request) starts a commit. At that edge: snap ← dirty; dirty ← the current-cycle write bit only; ptr ← 0; go to SCAN.
  - SCAN: every cycle the stage register ← {snap[ptr], ptr, shadow[ptr]}. If the previous stage is valid, active[stage_id] ← stage_data. ptr increments each cycle. Go to DRAIN after ptr = `NUM_MATS`-1.
  - DRAIN: write the last stage, then return to IDLE.
- Writes during a commit are always accepted into shadow.
  - Same-cycle write and copy read of the same index: the copy takes the old value.
  - That entry stays dirty for the next commit.
- `commit_req` while `busy` sets a pending flag. The next commit starts on the edge after DRAIN ends. Additional requests during the same commit collapse into one.
- `commit_req` with an all-zero dirty mask still runs a full scan. Active is unchanged; `commit_done` still pulses.
- Read ports:
  - Each port independently registers active[rd_id].
  - A read and a commit write to the same entry on the same edge return the old value.
  - A `rd_id` ≥ `NUM_MATS` returns all zeros.

## Timing
- Reset values: `busy`=0, `commit_done`=0, all read outputs 0. Dirty mask, pending flag and pointer are cleared; FSM goes to IDLE.
- Read latency: 1 cycle, full throughput on every port.
- Commit timing:
  - `commit_req` sampled at edge E0 → `busy`=1 from E0 until edge E0+`NUM_MATS`+1.
  - At E0+`NUM_MATS`+1, `busy` falls and `commit_done` rises, both for the same cycle.
  - Entry i is updated in active at edge E0+i+2.
- Reads issued in the `commit_done` cycle see fully committed data.
- Reset during a commit aborts it at once.
  - Active keeps any entries already copied.
  - Uncopied dirty entries are lost from the mask; the host must rewrite them.

## Structure
- Package `material_pkg` holds:
  - `FRAC_W`=24 and `FIX_ONE`.
  - Entry field offsets and widths.
  - The `ENTRY_W` function.
  - The FSM state enum: IDLE, SCAN, DRAIN.
- Sub-module `material_bank`: an `NUM_MATS`×`ENTRY_W` memory with one synchronous write port and `NUM_RD` registered read-before-write read ports. It is instantiated twice: shadow (`NUM_RD`=1, used by the scanner) and active.

## Test plan
- Reset, then read ids 0, 1, 2, 7 on port 0 → diffuse (0x0100_0000,0,0), (0,0x0100_0000,0), (0,0,0x0100_0000), then 0; `is_diffuse` 1, 1, 1, 0.
- Write entry 5 (diffuse 0,0,0x0080_0000), no commit → read 5 returns 0. Commit → `busy` for 9 cycles, `commit_done` at E0+9, then read 5 returns 0x0080_0000.
- Dirty-only copy: write entries 1 and 6, commit → only active entries 1 and 6 change; entries 0, 2 to 5 and 7 are bit-identical.
- During a commit, write entry 0 after it was copied and entry 7 before it is reached, and send a second `commit_req` → the first commit copies entry 7 but not the entry-0 write. An automatic second commit follows and copies entry 0.
- Both ports read entry 3 while a commit writes entry 3 on the same edge → both return the old value, the new value one cycle later. `rd_id`=9 with `NUM_MATS`=10 is valid; with `NUM_MATS`=8 it returns 0.
- Assert `rst` at E0+4 → `busy`=0 next cycle and no `commit_done`. Entries 0 to 1 are committed and entries 2 onward are unchanged.

Source files
------------

// File: rtl/material_pkg.sv
// Shared constants, entry layout helpers and commit FSM states for the
// double-buffered material table.
package material_pkg;

  localparam int unsigned FRAC_W  = 24;
  localparam int unsigned FIX_ONE = 32'd1 << FRAC_W;
  localparam int unsigned RGB_CH  = 3;
  localparam int unsigned AMB_OFF = 0;

  function automatic int unsigned rgb_w(input int unsigned color_w);
    return RGB_CH * color_w;
  endfunction

  function automatic int unsigned entry_w(input int unsigned color_w);
    return 9 * color_w + 1;
  endfunction

  function automatic int unsigned dif_off(input int unsigned color_w);
    return rgb_w(color_w);
  endfunction

  function automatic int unsigned refl_off(input int unsigned color_w);
    return 2 * rgb_w(color_w);
  endfunction

  function automatic int unsigned isd_off(input int unsigned color_w);
    return 3 * rgb_w(color_w);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } commit_state_e;

endpackage

// File: rtl/material_table_db_bank.sv
// Material storage: NUM_MATS entries, one synchronous write port and NUM_RD
// registered read-before-write read ports; out-of-range reads return zero.
module material_bank
  import material_pkg::*;
#(
  parameter int unsigned NUM_MATS     = 8,
  parameter int unsigned COLOR_W      = 32,
  parameter int unsigned NUM_RD       = 1,
  parameter bit          INIT_DEFAULT = 1'b0,
  localparam int unsigned ID_W        = $clog2(NUM_MATS),
  localparam int unsigned ENTRY_W     = entry_w(COLOR_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ID_W-1:0]           wr_id,
  input  logic [ENTRY_W-1:0]        wr_data,
  input  logic [NUM_RD*ID_W-1:0]    rd_id,
  output logic [NUM_RD*ENTRY_W-1:0] rd_data
);

  localparam int unsigned DIF_OFF = dif_off(COLOR_W);
  localparam int unsigned ISD_OFF = isd_off(COLOR_W);

  function automatic logic [ENTRY_W-1:0] init_entry(input int unsigned idx);
    logic [ENTRY_W-1:0] e;
    e = '0;
    if (INIT_DEFAULT && idx < RGB_CH) begin
      for (int unsigned c = 0; c < RGB_CH; c++) begin
        e[AMB_OFF + c*COLOR_W +: COLOR_W] = COLOR_W'(FIX_ONE);
      end
      e[DIF_OFF + idx*COLOR_W +: COLOR_W] = COLOR_W'(FIX_ONE);
      e[ISD_OFF] = 1'b1;
    end
    return e;
  endfunction

  logic [ENTRY_W-1:0]        mem [NUM_MATS];
  logic [NUM_RD*ENTRY_W-1:0] rd_q, rd_d;

  // Entries hold value XOR power-up image, so all-zero storage reads as the default table.
  for (genvar g = 0; g < NUM_MATS; g++) begin : g_ent
    localparam logic [ENTRY_W-1:0] IMG = init_entry(g);
    logic [ENTRY_W-1:0] ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (wr_en && wr_id == ID_W'(g)) ent_d = wr_data ^ IMG;
    end

    always_ff @(posedge clk) ent_q <= ent_d;

    assign mem[g] = ent_q ^ IMG;
  end

  always_comb begin
    rd_d = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (32'(rd_id[p*ID_W +: ID_W]) < NUM_MATS) begin
        rd_d[p*ENTRY_W +: ENTRY_W] = mem[rd_id[p*ID_W +: ID_W]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/material_table_db.sv
// Double-buffered material table: host writes go to a shadow bank; a commit
// copies dirty entries into the active bank one per cycle while reads continue.
module material_table_db
  import material_pkg::*;
#(
  parameter int unsigned NUM_MATS = 8,
  parameter int unsigned COLOR_W  = 32,
  parameter int unsigned NUM_RD   = 2,
  localparam int unsigned ID_W    = $clog2(NUM_MATS),
  localparam int unsigned ENTRY_W = entry_w(COLOR_W),
  localparam int unsigned RGB_W   = rgb_w(COLOR_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ID_W-1:0]         wr_id,
  input  logic [ENTRY_W-1:0]      wr_data,
  input  logic                    commit_req,
  output logic                    busy,
  output logic                    commit_done,
  input  logic [NUM_RD*ID_W-1:0]  rd_id,
  output logic [NUM_RD*RGB_W-1:0] rd_ambient,
  output logic [NUM_RD*RGB_W-1:0] rd_diffuse,
  output logic [NUM_RD*RGB_W-1:0] rd_reflection,
  output logic [NUM_RD-1:0]       rd_is_diffuse
);

  localparam int unsigned DIF_OFF  = dif_off(COLOR_W);
  localparam int unsigned REFL_OFF = refl_off(COLOR_W);
  localparam int unsigned ISD_OFF  = isd_off(COLOR_W);

  commit_state_e             state_q, state_d;
  logic [ID_W-1:0]           ptr_q, ptr_d;
  logic [NUM_MATS-1:0]       dirty_q, dirty_d, snap_q, snap_d, wr_bit;
  logic                      pending_q, pending_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic                      stage_vld_q, stage_vld_d;
  logic [ID_W-1:0]           stage_id_q, stage_id_d;
  logic                      start;
  logic [ENTRY_W-1:0]        stage_data;
  logic [NUM_RD*ENTRY_W-1:0] act_rd;

  assign wr_bit = (wr_en && 32'(wr_id) < NUM_MATS) ? (NUM_MATS'(1) << wr_id) : '0;
  assign start  = (state_q == IDLE) && (commit_req || pending_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      dirty_q     <= '0;
      snap_q      <= '0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_vld_q <= 1'b0;
      stage_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dirty_q     <= dirty_d;
      snap_q      <= snap_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stage_vld_q <= stage_vld_d;
      stage_id_q  <= stage_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (ptr_q == ID_W'(NUM_MATS - 1)) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dirty tracking, scan pointer and the copy stage feeding the active bank.
  always_comb begin
    dirty_d     = dirty_q | wr_bit;
    snap_d      = snap_q;
    ptr_d       = ptr_q;
    pending_d   = pending_q;
    stage_vld_d = 1'b0;
    stage_id_d  = ptr_q;
    if (start) begin
      snap_d    = dirty_q;
      dirty_d   = wr_bit;
      ptr_d     = '0;
      pending_d = 1'b0;
    end else if (state_q != IDLE && commit_req) begin
      pending_d = 1'b1;
    end
    if (state_q == SCAN) begin
      stage_vld_d = snap_q[ptr_q];
      ptr_d       = ptr_q + ID_W'(1);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_q == DRAIN);
  end

  assign busy        = busy_q;
  assign commit_done = done_q;

  material_bank #(
    .NUM_MATS(NUM_MATS), .COLOR_W(COLOR_W), .NUM_RD(1), .INIT_DEFAULT(1'b0)
  ) u_shadow (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .rd_id(ptr_q), .rd_data(stage_data)
  );

  // A reset edge must not land the in-flight stage in the active bank.
  material_bank #(
    .NUM_MATS(NUM_MATS), .COLOR_W(COLOR_W), .NUM_RD(NUM_RD), .INIT_DEFAULT(1'b1)
  ) u_active (
    .clk(clk), .rst(rst), .wr_en(stage_vld_q && !rst), .wr_id(stage_id_q),
    .wr_data(stage_data), .rd_id(rd_id), .rd_data(act_rd)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    assign rd_ambient[p*RGB_W +: RGB_W]    = act_rd[p*ENTRY_W + AMB_OFF +: RGB_W];
    assign rd_diffuse[p*RGB_W +: RGB_W]    = act_rd[p*ENTRY_W + DIF_OFF +: RGB_W];
    assign rd_reflection[p*RGB_W +: RGB_W] = act_rd[p*ENTRY_W + REFL_OFF +: RGB_W];
    assign rd_is_diffuse[p]                = act_rd[p*ENTRY_W + ISD_OFF];
  end

endmodule

// File: tb/tb_material_table_db.sv
// Directed self-checking bench for material_table_db (8-entry and 10-entry instances).
module tb_material_table_db;

  localparam int unsigned RW = 96;
  localparam int unsigned EW = 289;
  localparam logic [31:0] ONE = 32'h0100_0000;
  typedef logic [EW-1:0] entry_t;

  logic clk, rst;
  logic wr_en, commit_req, busy, commit_done;
  logic [2:0] wr_id;
  entry_t wr_data;
  logic [5:0] rd_id;
  logic [2*RW-1:0] rd_ambient, rd_diffuse, rd_reflection;
  logic [1:0] rd_is_diffuse;

  logic wr_en10, commit_req10, busy10, done10;
  logic [3:0] wr_id10;
  entry_t wr_data10;
  logic [7:0] rd_id10;
  logic [2*RW-1:0] rd_ambient10, rd_diffuse10, rd_reflection10;
  logic [1:0] rd_is_diffuse10;

  entry_t exp_act [8];
  int n_checks, n_fail;

  material_table_db dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .commit_req(commit_req), .busy(busy), .commit_done(commit_done), .rd_id(rd_id),
    .rd_ambient(rd_ambient), .rd_diffuse(rd_diffuse), .rd_reflection(rd_reflection),
    .rd_is_diffuse(rd_is_diffuse)
  );

  material_table_db #(.NUM_MATS(10)) dut10 (
    .clk(clk), .rst(rst), .wr_en(wr_en10), .wr_id(wr_id10), .wr_data(wr_data10),
    .commit_req(commit_req10), .busy(busy10), .commit_done(done10), .rd_id(rd_id10),
    .rd_ambient(rd_ambient10), .rd_diffuse(rd_diffuse10), .rd_reflection(rd_reflection10),
    .rd_is_diffuse(rd_is_diffuse10)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [RW-1:0] rgb(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    return {b, g, r};
  endfunction

  function automatic entry_t mk(input logic [RW-1:0] a, input logic [RW-1:0] d,
                                input logic [RW-1:0] r, input logic isd);
    return {isd, r, d, a};
  endfunction

  function automatic entry_t pat(input logic [31:0] s);
    return mk(rgb(s, s + 1, s + 2), rgb(s + 3, s + 4, s + 5), rgb(s + 6, s + 7, s + 8), s[0]);
  endfunction

  function automatic entry_t port_entry(input int p);
    return {rd_is_diffuse[p], rd_reflection[p*RW +: RW], rd_diffuse[p*RW +: RW], rd_ambient[p*RW +: RW]};
  endfunction

  function automatic entry_t port10(input int p);
    return {rd_is_diffuse10[p], rd_reflection10[p*RW +: RW], rd_diffuse10[p*RW +: RW], rd_ambient10[p*RW +: RW]};
  endfunction

  task automatic read2(input logic [2:0] id0, input logic [2:0] id1);
    rd_id = {id1, id0};
    @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] id, input entry_t e);
    wr_en = 1'b1; wr_id = id; wr_data = e;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_commit();
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
  endtask

  // Returns the 1-based negedge index at which commit_done is seen (-1 on timeout).
  task automatic wait_done(input int budget, output int cyc, output bit busy_ok);
    cyc = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      if (commit_done) begin
        cyc = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_id = '0; wr_data = '0; commit_req = 1'b0; rd_id = '0;
    wr_en10 = 1'b0; wr_id10 = '0; wr_data10 = '0; commit_req10 = 1'b0; rd_id10 = '0;
    for (int i = 0; i < 8; i++) exp_act[i] = '0;
    exp_act[0] = mk(rgb(ONE, ONE, ONE), rgb(ONE, 0, 0), '0, 1'b1);
    exp_act[1] = mk(rgb(ONE, ONE, ONE), rgb(0, ONE, 0), '0, 1'b1);
    exp_act[2] = mk(rgb(ONE, ONE, ONE), rgb(0, 0, ONE), '0, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (commit_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", commit_done); end
    n_checks++;
    if ({rd_ambient, rd_diffuse, rd_reflection, rd_is_diffuse} !== '0) begin
      n_fail++; $display("FAIL reset_rd_zero: got %h want 0", {rd_ambient, rd_diffuse, rd_reflection, rd_is_diffuse});
    end
    rst = 1'b0;
    read2(3'd0, 3'd1);
    n_checks++;
    if (port_entry(0) !== exp_act[0]) begin n_fail++; $display("FAIL init_rd0: got %h want %h", port_entry(0), exp_act[0]); end
    n_checks++;
    if (port_entry(1) !== exp_act[1]) begin n_fail++; $display("FAIL init_rd1: got %h want %h", port_entry(1), exp_act[1]); end
    read2(3'd2, 3'd7);
    n_checks++;
    if (port_entry(0) !== exp_act[2]) begin n_fail++; $display("FAIL init_rd2: got %h want %h", port_entry(0), exp_act[2]); end
    n_checks++;
    if (port_entry(1) !== '0) begin n_fail++; $display("FAIL init_rd7: got %h want 0", port_entry(1)); end
  endtask

  task automatic test_commit_basic();
    entry_t e5;
    int cyc;
    bit bok;
    e5 = mk('0, rgb(0, 0, 32'h0080_0000), '0, 1'b1);
    do_write(3'd5, e5);
    read2(3'd5, 3'd5);
    n_checks++;
    if (port_entry(0) !== '0) begin n_fail++; $display("FAIL uncommitted_rd5: got %h want 0", port_entry(0)); end
    start_commit();
    wait_done(30, cyc, bok);
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL commit_latency: got %0d want 10", cyc); end
    n_checks++;
    if (bok !== 1'b1) begin n_fail++; $display("FAIL busy_window: got %b want 1", bok); end
    exp_act[5] = e5;
    read2(3'd5, 3'd0);
    n_checks++;
    if (port_entry(0) !== e5) begin n_fail++; $display("FAIL committed_rd5: got %h want %h", port_entry(0), e5); end
    n_checks++;
    if ({busy, commit_done} !== 2'b00) begin n_fail++; $display("FAIL done_pulse_width: got %b want 00", {busy, commit_done}); end
  endtask

  task automatic test_dirty_only();
    int cyc;
    bit bok;
    do_write(3'd1, pat(32'h1000_0000));
    do_write(3'd6, pat(32'h6000_0001));
    start_commit();
    wait_done(30, cyc, bok);
    exp_act[1] = pat(32'h1000_0000);
    exp_act[6] = pat(32'h6000_0001);
    for (int i = 0; i < 4; i++) begin
      read2(3'(i), 3'(7 - i));
      n_checks++;
      if (port_entry(0) !== exp_act[i]) begin
        n_fail++; $display("FAIL dirty_only_rd%0d: got %h want %h", i, port_entry(0), exp_act[i]);
      end
      n_checks++;
      if (port_entry(1) !== exp_act[7-i]) begin
        n_fail++; $display("FAIL dirty_only_rd%0d: got %h want %h", 7 - i, port_entry(1), exp_act[7-i]);
      end
    end
  endtask

  task automatic test_overlap();
    int cyc;
    bit bok;
    entry_t a0, a7, b0, b7;
    a0 = pat(32'hA000_0000); a7 = pat(32'hA700_0000);
    b0 = pat(32'hB000_0001); b7 = pat(32'hB700_0001);
    do_write(3'd0, a0);
    do_write(3'd7, a7);
    start_commit();
    // Entry 0 rewritten on the same edge its copy is read; entry 7 well before its turn.
    do_write(3'd0, b0);
    wr_en = 1'b1; wr_id = 3'd7; wr_data = b7; commit_req = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; commit_req = 1'b0;
    wait_done(30, cyc, bok);
    n_checks++;
    if (cyc < 1) begin n_fail++; $display("FAIL overlap_first_done: got %0d want >0", cyc); end
    read2(3'd0, 3'd7);
    n_checks++;
    if (port_entry(0) !== a0) begin n_fail++; $display("FAIL overlap_first_rd0: got %h want %h", port_entry(0), a0); end
    n_checks++;
    if (port_entry(1) !== b7) begin n_fail++; $display("FAIL overlap_first_rd7: got %h want %h", port_entry(1), b7); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pending_restart: got %b want 1", busy); end
    wait_done(30, cyc, bok);
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL pending_latency: got %0d want 10", cyc); end
    exp_act[0] = b0;
    exp_act[7] = b7;
    read2(3'd0, 3'd7);
    n_checks++;
    if (port_entry(0) !== b0) begin n_fail++; $display("FAIL overlap_second_rd0: got %h want %h", port_entry(0), b0); end
    n_checks++;
    if (port_entry(1) !== b7) begin n_fail++; $display("FAIL overlap_second_rd7: got %h want %h", port_entry(1), b7); end
  endtask

  task automatic test_rw_collision();
    int cyc;
    bit bok;
    entry_t c3, old3;
    c3 = pat(32'hC300_0000);
    old3 = exp_act[3];
    do_write(3'd3, c3);
    start_commit();
    repeat (4) @(negedge clk);
    read2(3'd3, 3'd3);
    n_checks++;
    if (port_entry(0) !== old3) begin n_fail++; $display("FAIL collide_p0_old: got %h want %h", port_entry(0), old3); end
    n_checks++;
    if (port_entry(1) !== old3) begin n_fail++; $display("FAIL collide_p1_old: got %h want %h", port_entry(1), old3); end
    @(negedge clk);
    n_checks++;
    if (port_entry(0) !== c3) begin n_fail++; $display("FAIL collide_p0_new: got %h want %h", port_entry(0), c3); end
    n_checks++;
    if (port_entry(1) !== c3) begin n_fail++; $display("FAIL collide_p1_new: got %h want %h", port_entry(1), c3); end
    exp_act[3] = c3;
    wait_done(30, cyc, bok);
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL collide_done_time: got %0d want 4", cyc); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit bok, saw_done;
    entry_t d [4];
    for (int i = 0; i < 4; i++) begin
      d[i] = pat(32'hD000_0000 + 32'(i) * 32'h10);
      do_write(3'(i), d[i]);
    end
    start_commit();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++;
    if (commit_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", commit_done); end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (commit_done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    exp_act[0] = d[0];
    exp_act[1] = d[1];
    read2(3'd0, 3'd1);
    n_checks++;
    if (port_entry(0) !== d[0]) begin n_fail++; $display("FAIL abort_rd0: got %h want %h", port_entry(0), d[0]); end
    n_checks++;
    if (port_entry(1) !== d[1]) begin n_fail++; $display("FAIL abort_rd1: got %h want %h", port_entry(1), d[1]); end
    read2(3'd2, 3'd3);
    n_checks++;
    if (port_entry(0) !== exp_act[2]) begin n_fail++; $display("FAIL abort_rd2: got %h want %h", port_entry(0), exp_act[2]); end
    n_checks++;
    if (port_entry(1) !== exp_act[3]) begin n_fail++; $display("FAIL abort_rd3: got %h want %h", port_entry(1), exp_act[3]); end
    // Dirty bits were dropped by the reset: an empty commit still scans fully.
    start_commit();
    wait_done(30, cyc, bok);
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL empty_commit_latency: got %0d want 10", cyc); end
    read2(3'd2, 3'd3);
    n_checks++;
    if (port_entry(0) !== exp_act[2]) begin n_fail++; $display("FAIL lost_rd2: got %h want %h", port_entry(0), exp_act[2]); end
    n_checks++;
    if (port_entry(1) !== exp_act[3]) begin n_fail++; $display("FAIL lost_rd3: got %h want %h", port_entry(1), exp_act[3]); end
  endtask

  task automatic test_nonpow2();
    int cyc;
    entry_t e9;
    e9 = pat(32'h0900_0000);
    wr_en10 = 1'b1; wr_id10 = 4'd9; wr_data10 = e9;
    @(negedge clk);
    wr_id10 = 4'd11; wr_data10 = pat(32'h0B00_0000);
    @(negedge clk);
    wr_en10 = 1'b0;
    commit_req10 = 1'b1;
    @(negedge clk);
    commit_req10 = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      if (done10) begin cyc = k; break; end
      @(negedge clk);
    end
    n_checks++;
    if (cyc !== 12) begin n_fail++; $display("FAIL n10_latency: got %0d want 12", cyc); end
    rd_id10 = {4'd11, 4'd9};
    @(negedge clk);
    n_checks++;
    if (port10(0) !== e9) begin n_fail++; $display("FAIL n10_rd9: got %h want %h", port10(0), e9); end
    n_checks++;
    if (port10(1) !== '0) begin n_fail++; $display("FAIL n10_rd11: got %h want 0", port10(1)); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_commit_basic();
    test_dirty_only();
    test_overlap();
    test_rw_collision();
    test_reset_abort();
    test_nonpow2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
